// File: rtl/bpred_pkg.sv
// Shared definitions for the branch predictor: mode constants, the counter
// reset value and the branch target buffer entry layout.
package bpred_pkg;

    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;

    // Field widths cover the widest legal tag (IDX_W >= 1 leaves <= 29 bits).
    localparam int BTB_TAG_BITS = 30;
    localparam int BTB_TGT_BITS = 30;

    typedef struct packed {
        logic                    valid;
        logic [BTB_TAG_BITS-1:0] tag;
        logic [BTB_TGT_BITS-1:0] target;
    } btb_entry_t;

    // Weakly-not-taken: one below the counter midpoint.
    function automatic int cnt_reset(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up/down saturating counter. It holds at all-ones and at zero and never wraps.
module sat_counter #(
    parameter int           W    = 2,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ONE = W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= INIT;
        end else if (en) begin
            if (inc) begin
                if (cnt != '1) cnt <= cnt + ONE;
            end else begin
                if (cnt != '0) cnt <= cnt - ONE;
            end
        end
    end

endmodule

// File: rtl/bpred_table.sv
// Branch predictor: a PHT of saturating counters plus a tagged direct-mapped BTB.
// Lookup is combinational and runs in parallel with the non-speculative update from ID.
module bpred_table
    import bpred_pkg::*;
#(
    parameter int IDX_W  = 6,
    parameter int CNT_W  = 2,
    parameter int TAG_W  = 8,
    parameter int GHR_W  = 6,
    parameter int MODE   = 0,
    parameter int PERF_W = 32
) (
    input  logic              i_clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [29:0]       lk_pc,
    output logic              lk_hit,
    output logic              lk_taken,
    output logic [29:0]       lk_target,
    output logic [IDX_W-1:0]  lk_idx,
    input  logic              up_valid,
    input  logic [29:0]       up_pc,
    input  logic [IDX_W-1:0]  up_idx,
    input  logic              up_taken,
    input  logic [29:0]       up_target,
    input  logic              up_mispred,
    output logic [GHR_W-1:0]  ghr,
    output logic [PERF_W-1:0] perf_br,
    output logic [PERF_W-1:0] perf_mis
);

    localparam int                N        = 1 << IDX_W;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(cnt_reset(CNT_W));
    localparam logic [PERF_W-1:0] P_ONE    = PERF_W'(1);

    // Update handshake: up_valid is the only qualifier and stall acts as the
    // not-ready side. A branch is consumed on the edge where up_valid && !stall.
    logic upd;
    assign upd = up_valid && !stall;

    logic [CNT_W-1:0] pht [N];

    for (genvar i = 0; i < N; i++) begin : g_pht
        sat_counter #(
            .W    (CNT_W),
            .INIT (CNT_INIT)
        ) u_cnt (
            .clk (i_clk),
            .rst (rst),
            .en  (upd && (up_idx == IDX_W'(i))),
            .inc (up_taken),
            .cnt (pht[i])
        );
    end

    btb_entry_t       btb [N];
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;

    assign wr_idx = up_pc[IDX_W-1:0];
    assign wr_tag = up_pc[IDX_W+TAG_W-1:IDX_W];

    // Only taken branches allocate; a taken write evicts whatever aliased there.
    always_ff @(posedge i_clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) btb[k].valid <= 1'b0;
        end else if (upd && up_taken) begin
            btb[wr_idx].valid  <= 1'b1;
            btb[wr_idx].tag    <= BTB_TAG_BITS'(wr_tag);
            btb[wr_idx].target <= up_target;
        end
    end

    logic [GHR_W-1:0] ghr_q;

    if (MODE == MODE_GSHARE) begin : g_ghr
        always_ff @(posedge i_clk) begin
            if (rst) ghr_q <= '0;
            else if (upd) ghr_q <= (ghr_q << 1) | GHR_W'(up_taken);
        end
    end else begin : g_no_ghr
        assign ghr_q = '0;
    end

    assign ghr = ghr_q;

    always_ff @(posedge i_clk) begin
        if (rst) begin
            perf_br  <= '0;
            perf_mis <= '0;
        end else if (upd) begin
            if (perf_br != '1) perf_br <= perf_br + P_ONE;
            if (up_mispred && (perf_mis != '1)) perf_mis <= perf_mis + P_ONE;
        end
    end

    logic [IDX_W-1:0] lk_bidx;
    logic [TAG_W-1:0] lk_tag;
    btb_entry_t       lk_ent;

    assign lk_bidx = lk_pc[IDX_W-1:0];
    assign lk_tag  = lk_pc[IDX_W+TAG_W-1:IDX_W];
    assign lk_ent  = btb[lk_bidx];

    // Reads see pre-update state; a same-cycle update becomes visible next cycle.
    assign lk_idx    = (MODE == MODE_GSHARE) ? (lk_bidx ^ IDX_W'(ghr_q)) : lk_bidx;
    assign lk_hit    = lk_ent.valid && (lk_ent.tag[TAG_W-1:0] == lk_tag);
    assign lk_taken  = lk_hit && pht[lk_idx][CNT_W-1];
    assign lk_target = lk_hit ? lk_ent.target : '0;

    logic unused_bits;
    assign unused_bits = ^{lk_pc, up_pc, lk_ent.tag};

endmodule

// File: tb/tb_bpred_table.sv
// Bench for bpred_table: a bimodal instance (PERF_W=4) and a gshare instance
// share one stimulus stream and are both checked against an array-based model.
module tb_bpred_table;

    logic        i_clk = 1'b0;
    logic        rst = 1'b1, stall = 1'b0;
    logic        up_valid = 1'b0, up_taken = 1'b0, up_mispred = 1'b0;
    logic [29:0] lk_pc = '0, up_pc = '0, up_target = '0;
    logic [5:0]  up_idx_b = '0, up_idx_g = '0;

    logic        b_hit, b_taken, g_hit, g_taken;
    logic [29:0] b_target, g_target;
    logic [5:0]  b_idx, g_idx, b_ghr, g_ghr;
    logic [3:0]  b_br, b_mis;
    logic [31:0] g_br, g_mis;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    bpred_table #(.IDX_W(6), .CNT_W(2), .TAG_W(8), .GHR_W(6), .MODE(0), .PERF_W(4)) dut_b (
        .i_clk(i_clk), .rst(rst), .stall(stall), .lk_pc(lk_pc),
        .lk_hit(b_hit), .lk_taken(b_taken), .lk_target(b_target), .lk_idx(b_idx),
        .up_valid(up_valid), .up_pc(up_pc), .up_idx(up_idx_b), .up_taken(up_taken),
        .up_target(up_target), .up_mispred(up_mispred),
        .ghr(b_ghr), .perf_br(b_br), .perf_mis(b_mis)
    );

    bpred_table #(.IDX_W(6), .CNT_W(2), .TAG_W(8), .GHR_W(6), .MODE(1), .PERF_W(32)) dut_g (
        .i_clk(i_clk), .rst(rst), .stall(stall), .lk_pc(lk_pc),
        .lk_hit(g_hit), .lk_taken(g_taken), .lk_target(g_target), .lk_idx(g_idx),
        .up_valid(up_valid), .up_pc(up_pc), .up_idx(up_idx_g), .up_taken(up_taken),
        .up_target(up_target), .up_mispred(up_mispred),
        .ghr(g_ghr), .perf_br(g_br), .perf_mis(g_mis)
    );

    // ---------------- behavioural model (index 0 = bimodal, 1 = gshare) ----------------
    int     m_pht [2][64];
    bit     m_v   [2][64];
    int     m_tag [2][64];
    int     m_tgt [2][64];
    int     m_ghr [2];
    longint m_br  [2];
    longint m_mis [2];

    function automatic longint pmax(input int d);
        return (d == 0) ? 64'd15 : 64'd4294967295;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 64; k++) begin
                m_pht[d][k] = 1;
                m_v[d][k]   = 1'b0;
                m_tag[d][k] = 0;
                m_tgt[d][k] = 0;
            end
            m_ghr[d] = 0;
            m_br[d]  = 0;
            m_mis[d] = 0;
        end
    endtask

    always @(posedge i_clk) begin
        int ui, bi;
        if (rst) begin
            model_reset();
        end else if (up_valid && !stall) begin
            for (int d = 0; d < 2; d++) begin
                ui = (d == 0) ? int'(up_idx_b) : int'(up_idx_g);
                bi = int'(up_pc) % 64;
                if (up_taken) m_pht[d][ui] = (m_pht[d][ui] == 3) ? 3 : m_pht[d][ui] + 1;
                else          m_pht[d][ui] = (m_pht[d][ui] == 0) ? 0 : m_pht[d][ui] - 1;
                if (up_taken) begin
                    m_v[d][bi]   = 1'b1;
                    m_tag[d][bi] = (int'(up_pc) / 64) % 256;
                    m_tgt[d][bi] = int'(up_target);
                end
                m_ghr[d] = (d == 1) ? (m_ghr[d] * 2 + int'(up_taken)) % 64 : 0;
                if (m_br[d] < pmax(d)) m_br[d] = m_br[d] + 1;
                if (up_mispred && (m_mis[d] < pmax(d))) m_mis[d] = m_mis[d] + 1;
            end
        end
    end

    function automatic void model_lookup(input int d, input int pc, output bit hit,
                                         output bit tk, output int tgt, output int idx);
        int bi, tg;
        bi  = pc % 64;
        tg  = (pc / 64) % 256;
        hit = m_v[d][bi] && (m_tag[d][bi] == tg);
        idx = (d == 1) ? (bi ^ m_ghr[d]) : bi;
        tk  = hit && (m_pht[d][idx] >= 2);
        tgt = hit ? m_tgt[d][bi] : 0;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic cmp(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input longint act, input logic [31:0] exp);
        exp_q.push_back(exp);
        cmp(name, act, longint'(exp_q.pop_front()));
    endtask

    always @(negedge i_clk) begin
        bit eh, et;
        int eg, ei;
        if (!rst) begin
            model_lookup(0, int'(lk_pc), eh, et, eg, ei);
            cmp("b_hit", b_hit, eh);
            cmp("b_taken", b_taken, et);
            cmp("b_target", b_target, eg);
            cmp("b_idx", b_idx, ei);
            cmp("b_ghr", b_ghr, m_ghr[0]);
            cmp("b_perf_br", b_br, m_br[0]);
            cmp("b_perf_mis", b_mis, m_mis[0]);
            model_lookup(1, int'(lk_pc), eh, et, eg, ei);
            cmp("g_hit", g_hit, eh);
            cmp("g_taken", g_taken, et);
            cmp("g_target", g_target, eg);
            cmp("g_idx", g_idx, ei);
            cmp("g_ghr", g_ghr, m_ghr[1]);
            cmp("g_perf_br", g_br, m_br[1]);
            cmp("g_perf_mis", g_mis, m_mis[1]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1; up_valid = 1'b0; stall = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive_up(input int pc, input bit tk, input int tgt, input bit mis);
        up_valid   = 1'b1;
        up_pc      = 30'(pc);
        up_taken   = tk;
        up_target  = 30'(tgt);
        up_mispred = mis;
        up_idx_b   = 6'(pc % 64);
        up_idx_g   = 6'((pc % 64) ^ m_ghr[1]);
    endtask

    task automatic update(input int pc, input bit tk, input int tgt, input bit mis);
        tick();
        drive_up(pc, tk, tgt, mis);
        tick();
        up_valid = 1'b0;
    endtask

    task automatic look(input int pc);
        tick();
        lk_pc = 30'(pc);
        @(negedge i_clk);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        do_reset();
        look('h10);
        lit("rst_hit", b_hit, 0);
        lit("rst_taken", b_taken, 0);
        lit("rst_target", b_target, 0);
        lit("rst_perf_br", b_br, 0);
        lit("rst_ghr", g_ghr, 0);

        // bimodal training: 01 -> 10 -> 11 -> 11
        update('h10, 1, 'h40, 0);
        update('h10, 1, 'h40, 0);
        look('h10);
        lit("train2_taken", b_taken, 1);
        lit("train2_target", b_target, 'h40);
        update('h10, 1, 'h40, 0);
        look('h10);
        lit("train3_taken", b_taken, 1);
        lit("train3_perf_br", b_br, 3);

        // alias: 0x50 shares BTB index 0x10 with tag 1
        update('h50, 1, 'h80, 0);
        look('h10);
        lit("alias_old_hit", b_hit, 0);
        look('h50);
        lit("alias_new_hit", b_hit, 1);
        lit("alias_new_target", b_target, 'h80);

        // gshare history T, N, T
        do_reset();
        update('h01, 1, 'h08, 0);
        update('h02, 0, 'h00, 0);
        update('h03, 1, 'h0c, 0);
        look('h03);
        lit("gs_ghr", g_ghr, 'h05);
        lit("gs_idx", g_idx, 'h06);
        lit("bm_idx", b_idx, 'h03);
        lit("bm_ghr", b_ghr, 0);

        // same-cycle lookup and update at index 5 with counter back at 01
        do_reset();
        update('h05, 1, 'h20, 0);
        update('h05, 0, 'h00, 0);
        tick();
        lk_pc = 30'h05;
        drive_up('h05, 1, 'h20, 0);
        @(negedge i_clk);
        lit("same_hit", b_hit, 1);
        lit("same_taken_before", b_taken, 0);
        tick();
        up_valid = 1'b0;
        @(negedge i_clk);
        lit("same_taken_after", b_taken, 1);

        // counter floor: three not-taken from 01 then one taken -> 01
        do_reset();
        for (int i = 0; i < 3; i++) update('h22, 0, 0, 0);
        update('h22, 1, 'h99, 0);
        look('h22);
        lit("floor_hit", b_hit, 1);
        lit("floor_taken", b_taken, 0);
        lit("floor_target", b_target, 'h99);
        look('h22 + 'h40);
        lit("tag_miss", b_hit, 0);

        // stall freezes the pending update; it counts once when stall drops
        do_reset();
        tick();
        stall = 1'b1;
        drive_up('h09, 0, 0, 1);
        repeat (3) begin
            @(negedge i_clk);
            lit("stall_perf_br", b_br, 0);
            lit("stall_perf_mis", g_mis, 0);
            @(posedge i_clk);
        end
        #1;
        stall = 1'b0;
        @(posedge i_clk);
        #1;
        up_valid = 1'b0;
        @(negedge i_clk);
        lit("unstall_perf_br", b_br, 1);
        lit("unstall_perf_mis", b_mis, 1);

        // 20 further mispredicts: 4-bit counters pin at 15, 32-bit reach 21
        tick();
        drive_up('h09, 0, 0, 1);
        repeat (20) @(posedge i_clk);
        #1;
        up_valid = 1'b0;
        @(negedge i_clk);
        lit("sat_perf_br", b_br, 15);
        lit("sat_perf_mis", b_mis, 15);
        lit("wide_perf_br", g_br, 21);
        lit("wide_perf_mis", g_mis, 21);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
